bf_jump_unit: RTL and testbench
===============================

BF_JUMP_UNIT -- requirements
Module: bf_jump_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, instruction address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 16, loop-stack entries (power of two).
REQ-003 SHALL have parameter SKIP_W, default 8, forward-skip nesting counter width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 instr_valid  input  1  one-cycle strobe: instr holds the opcode fetched at ip.
REQ-007 instr  input  8  ASCII opcode of the current instruction.
REQ-008 ip  input  ADDR_W  current instruction pointer from the IP controller.
REQ-009 cell_zero  input  1  data cell at the data pointer equals 0, valid with instr_valid.
REQ-010 op_done  input  1  execute unit has completed a non-bracket instruction.
REQ-011 update_ip  output  1  one-cycle strobe: advance or jump the IP.
REQ-012 jmp  output  1  qualifies update_ip: load jmp_target instead of ip+1.
REQ-013 jmp_target  output  ADDR_W  jump destination, valid when jmp=1.
REQ-014 skipping  output  1  high while in SKIP; execute unit shall ignore instructions.
REQ-015 err_overflow / err_underflow  output  1 each  sticky error flags.

Function
REQ-016 States: RUN, SKIP, ERR; update_ip, jmp, jmp_target combinational from state, stack top and inputs.
REQ-017 RUN, instr_valid, instr not 0x5B/0x5D: update_ip=op_done, jmp=0.
REQ-018 RUN, '[' (0x5B), cell_zero=1: update_ip=1, jmp=0, depth<=1, next SKIP; stack unchanged.
REQ-019 RUN, '[', cell_zero=0, stack not full: push ip, update_ip=1, jmp=0.
REQ-020 RUN, '[', cell_zero=0, stack full: no push, update_ip=0, err_overflow<=1, next ERR.
REQ-021 RUN, ']' (0x5D), stack empty: update_ip=0, err_underflow<=1, next ERR.
REQ-022 RUN, ']', cell_zero=1: pop, update_ip=1, jmp=0.
REQ-023 RUN, ']', cell_zero=0: no pop, update_ip=1, jmp=1, jmp_target=top+1 (wraps modulo 2^ADDR_W).
REQ-024 SKIP, instr_valid: update_ip=1, jmp=0 regardless of opcode; op_done and cell_zero ignored.
REQ-025 SKIP, '[': depth+1; if depth is all-ones, err_overflow<=1, update_ip=0, next ERR.
REQ-026 SKIP, ']': depth-1; when result is 0, next RUN; stack untouched.
REQ-027 SKIP, other opcodes: depth unchanged.
REQ-028 ERR: update_ip=0, jmp=0, no stack activity; exited only by reset.
REQ-029 instr_valid=0: update_ip=0, jmp=0, no state change in any state.
REQ-030 At most one stack operation per cycle; push and pop never occur together.

Reset
REQ-031 On rst_n=0 at clk edge: state RUN, stack empty, depth 0, err flags 0.
REQ-032 During reset, update_ip=0, jmp=0, skipping=0, jmp_target=0.
REQ-033 Reset mid-SKIP or with stack non-empty discards all loop state.

Structure
REQ-034 Shared package bf_pkg SHALL hold opcode constants (OP_LOOP_OPEN 8'h5B, OP_LOOP_CLOSE 8'h5D) and the state enum.
REQ-035 Loop stack SHALL be sub-module bf_loop_stack (push, pop, top, empty, full; synchronous reset).

Verification
REQ-036 Program "[+]" at 0, cell_zero=1 at ip 0 -> SKIP, update_ip on ips 0,1,2, RUN after ']' at ip 2, stack empty.
REQ-037 '[' at ip 5, cell_zero=0; ']' at ip 9, cell_zero=0 -> jmp=1, jmp_target=6; then ']' with cell_zero=1 -> pop, jmp=0, stack empty.
REQ-038 Skip over "[[]]" at 0 with cell_zero=1 -> depth 1,2,1,0; RUN after ip 3, no jmp.
REQ-039 ']' with empty stack -> err_underflow=1, ERR, update_ip stays 0 until reset.
REQ-040 STACK_DEPTH+1 nested '[' with cell_zero=0 -> err_overflow on last; assert rst_n=0 -> flags clear, RUN.
REQ-041 Non-bracket op with op_done=0 for 3 cycles then 1 -> exactly one update_ip, jmp=0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared opcode constants and controller state encoding for the BF core.
package bf_pkg;

  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;  // ']'

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SKIP = 2'd1,
    ST_ERR  = 2'd2
  } bf_state_e;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-open addresses. One operation per cycle; the caller
// guarantees push never hits a full stack and pop never hits an empty one.
module bf_loop_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;

  // count==STACK_DEPTH wraps the low bits to 0, so top_idx still lands on the last entry
  assign wr_idx  = count[PTR_W-1:0];
  assign top_idx = wr_idx - PTR_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(STACK_DEPTH));

  // occupancy counter; reset empties the stack without clearing storage
  always_ff @(posedge clk) begin
    if (!rst_n)            count <= '0;
    else if (push && !full) count <= count + 1'b1;
    else if (pop && !empty) count <= count - 1'b1;
  end

  // entry storage, written only on push
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/bf_jump_unit.sv
// Bracket/jump controller: decides when the IP advances or jumps, tracks
// open loops on a stack, and forward-skips loop bodies entered with a zero cell.
module bf_jump_unit
  import bf_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16,
  parameter int SKIP_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  input  logic [ADDR_W-1:0] ip,
  input  logic              cell_zero,
  input  logic              op_done,
  output logic              update_ip,
  output logic              jmp,
  output logic [ADDR_W-1:0] jmp_target,
  output logic              skipping,
  output logic              err_overflow,
  output logic              err_underflow
);

  bf_state_e         state, state_nxt;
  logic [SKIP_W-1:0] depth, depth_nxt;
  logic              push, pop, ovf_set, unf_set;
  logic [ADDR_W-1:0] top;
  logic              stk_empty, stk_full;

  bf_loop_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (ip),
    .top       (top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  // next-state / strobe decode; everything is held off while reset is asserted
  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    update_ip = 1'b0;
    jmp       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (rst_n && instr_valid) begin
      unique case (state)
        ST_RUN: begin
          if (instr == OP_LOOP_OPEN) begin
            if (cell_zero) begin
              update_ip = 1'b1;
              depth_nxt = SKIP_W'(1);
              state_nxt = ST_SKIP;
            end else if (!stk_full) begin
              push      = 1'b1;
              update_ip = 1'b1;
            end else begin
              ovf_set   = 1'b1;
              state_nxt = ST_ERR;
            end
          end else if (instr == OP_LOOP_CLOSE) begin
            if (stk_empty) begin
              unf_set   = 1'b1;
              state_nxt = ST_ERR;
            end else if (cell_zero) begin
              pop       = 1'b1;
              update_ip = 1'b1;
            end else begin
              update_ip = 1'b1;
              jmp       = 1'b1;
            end
          end else begin
            update_ip = op_done;
          end
        end
        ST_SKIP: begin
          update_ip = 1'b1;
          if (instr == OP_LOOP_OPEN) begin
            if (depth == '1) begin
              update_ip = 1'b0;
              ovf_set   = 1'b1;
              state_nxt = ST_ERR;
            end else begin
              depth_nxt = depth + 1'b1;
            end
          end else if (instr == OP_LOOP_CLOSE) begin
            depth_nxt = depth - 1'b1;
            if (depth == SKIP_W'(1)) state_nxt = ST_RUN;
          end
        end
        default: ;  // ST_ERR: frozen until reset
      endcase
    end
  end

  // jump back to the instruction just after the matching '['
  assign jmp_target = jmp ? top + ADDR_W'(1) : '0;
  assign skipping   = rst_n && (state == ST_SKIP);

  // controller state, skip depth and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      depth <= depth_nxt;
      if (ovf_set) err_overflow  <= 1'b1;
      if (unf_set) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bf_jump_unit.sv
// Directed bench for bf_jump_unit: one task per scenario, inline checks.
module tb_bf_jump_unit;
  localparam int ADDR_W = 16;
  localparam int STACK_DEPTH = 16;
  localparam int SKIP_W = 8;
  localparam logic [7:0] LB = 8'h5B, RB = 8'h5D, PL = 8'h2B;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic [7:0]        instr;
  logic [ADDR_W-1:0] ip;
  logic              cell_zero, op_done;
  logic              update_ip, jmp, skipping, err_overflow, err_underflow;
  logic [ADDR_W-1:0] jmp_target;

  int checks = 0;
  int errors = 0;

  bf_jump_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .SKIP_W(SKIP_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .ip(ip),
    .cell_zero(cell_zero), .op_done(op_done), .update_ip(update_ip), .jmp(jmp),
    .jmp_target(jmp_target), .skipping(skipping),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // drive one instruction slot at the falling edge; outputs settle 1 ns later
  task automatic drive(input logic v, input logic [7:0] op, input logic [ADDR_W-1:0] a,
                       input logic cz, input logic od);
    @(negedge clk);
    instr_valid = v; instr = op; ip = a; cell_zero = cz; op_done = od;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_valid = 1'b1; instr = LB; ip = 16'h0; cell_zero = 1'b0; op_done = 1'b1;
    #1;
    checks++; if ({update_ip, jmp, skipping} !== 3'b000 || jmp_target !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got upd=%b jmp=%b skip=%b tgt=%h want 0", update_ip, jmp, skipping, jmp_target); end
    @(negedge clk); #1;
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got ovf=%b unf=%b want 00", err_overflow, err_underflow); end
    rst_n = 1'b1; instr_valid = 1'b0;
  endtask

  task automatic test_skip_simple();
    logic [ADDR_W-1:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = ADDR_W'(i);
      drive(1'b1, (i == 0) ? LB : (i == 1) ? PL : RB, a, 1'b1, 1'b0);
      checks++; if (update_ip !== 1'b1 || jmp !== 1'b0) begin
        errors++; $display("FAIL skip_simple_upd ip=%0d got upd=%b jmp=%b want 1 0", i, update_ip, jmp); end
      drive(1'b0, PL, a, 1'b0, 1'b0);
      checks++; if (skipping !== (i < 2)) begin
        errors++; $display("FAIL skip_simple_state ip=%0d got skipping=%b want %b", i, skipping, i < 2); end
    end
    // stack must still be empty: a ']' now underflows
    drive(1'b1, RB, 16'd3, 1'b1, 1'b0);
    checks++; if (update_ip !== 1'b0) begin
      errors++; $display("FAIL skip_simple_empty got upd=%b want 0", update_ip); end
    drive(1'b0, PL, 16'd3, 1'b0, 1'b0);
    checks++; if (err_underflow !== 1'b1) begin
      errors++; $display("FAIL skip_simple_unf got %b want 1", err_underflow); end
  endtask

  task automatic test_loop();
    do_reset();
    drive(1'b1, LB, 16'd5, 1'b0, 1'b0);
    checks++; if (update_ip !== 1'b1 || jmp !== 1'b0) begin
      errors++; $display("FAIL loop_push got upd=%b jmp=%b want 1 0", update_ip, jmp); end
    drive(1'b1, RB, 16'd9, 1'b0, 1'b0);
    checks++; if (update_ip !== 1'b1 || jmp !== 1'b1 || jmp_target !== 16'd6) begin
      errors++; $display("FAIL loop_jump got upd=%b jmp=%b tgt=%0d want 1 1 6", update_ip, jmp, jmp_target); end
    drive(1'b1, RB, 16'd9, 1'b1, 1'b0);
    checks++; if (update_ip !== 1'b1 || jmp !== 1'b0) begin
      errors++; $display("FAIL loop_pop got upd=%b jmp=%b want 1 0", update_ip, jmp); end
    drive(1'b1, RB, 16'd10, 1'b1, 1'b0);
    checks++; if (update_ip !== 1'b0) begin
      errors++; $display("FAIL loop_empty got upd=%b want 0", update_ip); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, LB, 16'hFFFF, 1'b0, 1'b0);
    drive(1'b1, RB, 16'h0010, 1'b0, 1'b0);
    checks++; if (jmp !== 1'b1 || jmp_target !== 16'h0000) begin
      errors++; $display("FAIL wrap_target got jmp=%b tgt=%h want 1 0000", jmp, jmp_target); end
  endtask

  task automatic test_nested_skip();
    logic [7:0] prog [4];
    prog[0] = LB; prog[1] = LB; prog[2] = RB; prog[3] = RB;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, prog[i], ADDR_W'(i), 1'b1, 1'b1);
      checks++; if (update_ip !== 1'b1 || jmp !== 1'b0) begin
        errors++; $display("FAIL nested_upd ip=%0d got upd=%b jmp=%b want 1 0", i, update_ip, jmp); end
      drive(1'b0, PL, ADDR_W'(i), 1'b0, 1'b0);
      checks++; if (skipping !== (i < 3)) begin
        errors++; $display("FAIL nested_state ip=%0d got skipping=%b want %b", i, skipping, i < 3); end
    end
    drive(1'b1, PL, 16'd4, 1'b0, 1'b0);
    checks++; if (update_ip !== 1'b0) begin
      errors++; $display("FAIL nested_run got upd=%b want 0 (op_done=0 in RUN)", update_ip); end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1'b1, RB, 16'd0, 1'b0, 1'b0);
    checks++; if (update_ip !== 1'b0) begin
      errors++; $display("FAIL unf_upd got %b want 0", update_ip); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 2) ? LB : PL, ADDR_W'(i + 1), 1'b0, 1'b1);
      checks++; if (update_ip !== 1'b0 || err_underflow !== 1'b1 || err_overflow !== 1'b0) begin
        errors++; $display("FAIL unf_err cyc=%0d got upd=%b unf=%b ovf=%b want 0 1 0", i, update_ip, err_underflow, err_overflow); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= STACK_DEPTH; i++) begin
      drive(1'b1, LB, ADDR_W'(i), 1'b0, 1'b0);
      checks++; if (update_ip !== (i < STACK_DEPTH)) begin
        errors++; $display("FAIL ovf_push i=%0d got upd=%b want %b", i, update_ip, i < STACK_DEPTH); end
    end
    drive(1'b0, PL, 16'd0, 1'b0, 1'b0);
    checks++; if (err_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b want 1", err_overflow); end
    do_reset();
    #1;
    checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got ovf=%b unf=%b want 0 0", err_overflow, err_underflow); end
    drive(1'b1, PL, 16'd0, 1'b0, 1'b1);
    checks++; if (update_ip !== 1'b1) begin
      errors++; $display("FAIL ovf_run got upd=%b want 1", update_ip); end
  endtask

  task automatic test_skip_depth_overflow();
    do_reset();
    drive(1'b1, LB, 16'd0, 1'b1, 1'b0);
    for (int i = 1; i < 255; i++) drive(1'b1, LB, ADDR_W'(i), 1'b0, 1'b0);
    checks++; if (update_ip !== 1'b1 || skipping !== 1'b1) begin
      errors++; $display("FAIL skipovf_last_ok got upd=%b skip=%b want 1 1", update_ip, skipping); end
    drive(1'b1, LB, 16'd255, 1'b0, 1'b0);
    checks++; if (update_ip !== 1'b0) begin
      errors++; $display("FAIL skipovf_upd got %b want 0", update_ip); end
    drive(1'b0, PL, 16'd0, 1'b0, 1'b0);
    checks++; if (err_overflow !== 1'b1 || skipping !== 1'b0) begin
      errors++; $display("FAIL skipovf_flag got ovf=%b skip=%b want 1 0", err_overflow, skipping); end
  endtask

  task automatic test_op_done();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PL, 16'd7, 1'b0, 1'b0);
      checks++; if (update_ip !== 1'b0) begin
        errors++; $display("FAIL opdone_wait cyc=%0d got upd=%b want 0", i, update_ip); end
    end
    drive(1'b1, PL, 16'd7, 1'b0, 1'b1);
    checks++; if (update_ip !== 1'b1 || jmp !== 1'b0) begin
      errors++; $display("FAIL opdone_fire got upd=%b jmp=%b want 1 0", update_ip, jmp); end
    drive(1'b0, RB, 16'd8, 1'b0, 1'b1);
    checks++; if (update_ip !== 1'b0 || jmp !== 1'b0) begin
      errors++; $display("FAIL invalid_idle got upd=%b jmp=%b want 0 0", update_ip, jmp); end
  endtask

  task automatic test_reset_mid_skip();
    do_reset();
    drive(1'b1, LB, 16'd0, 1'b0, 1'b0);   // push
    drive(1'b1, LB, 16'd1, 1'b1, 1'b0);   // enter SKIP
    drive(1'b0, PL, 16'd2, 1'b0, 1'b0);
    checks++; if (skipping !== 1'b1) begin
      errors++; $display("FAIL midskip_enter got %b want 1", skipping); end
    do_reset();
    #1;
    checks++; if (skipping !== 1'b0) begin
      errors++; $display("FAIL midskip_reset got %b want 0", skipping); end
    drive(1'b1, RB, 16'd2, 1'b0, 1'b0);
    checks++; if (update_ip !== 1'b0 || jmp !== 1'b0) begin
      errors++; $display("FAIL midskip_stack got upd=%b jmp=%b want 0 0", update_ip, jmp); end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 8'h0; ip = '0; cell_zero = 1'b0; op_done = 1'b0;
    test_reset();
    test_skip_simple();
    test_loop();
    test_wrap();
    test_nested_skip();
    test_underflow();
    test_overflow();
    test_skip_depth_overflow();
    test_op_done();
    test_reset_mid_skip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
